icache_assoc: RTL and testbench

Parametrised instruction cache between the datapath fetch port and the memory arbiter: configurable set count, words per block and 1- or 2-way associativity with LRU replacement. Misses run a multi-word block fill FSM against memory; a synchronous `iflush` invalidates the whole array. Hits return the instruction combinationally in the request cycle.

---
 rtl/cpu_types_pkg.sv | 11 +
 rtl/icache_way.sv | 62 ++++++
 rtl/icache_assoc.sv | 185 ++++++++++++++++++
 tb/tb_icache_assoc.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the instruction cache.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: per-set valid bit, tag and block data,
// a combinational lookup port and a single-word write port used by fills.
module icache_way
    import cpu_types_pkg::*;
#(
    parameter int NSETS    = 16,
    parameter int BLKWORDS = 2,
    parameter int IDXW     = 4,
    parameter int CNTW     = 1,
    parameter int TAGW     = 25
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] rd_index,
    input  logic [TAGW-1:0] rd_tag,
    input  logic [CNTW-1:0] rd_offset,
    output logic            hit,
    output logic            valid,
    output logic [31:0]     rd_data,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_index,
    input  logic [CNTW-1:0] wr_offset,
    input  logic [31:0]     wr_data,
    input  logic [TAGW-1:0] wr_tag,
    input  logic            set_valid,
    input  logic            clr_valid,
    input  logic            flush
);

    logic [NSETS-1:0] valid_bits;
    logic [TAGW-1:0]  tags [NSETS];
    word_t            data [NSETS][BLKWORDS];

    assign valid   = valid_bits[rd_index];
    assign hit     = valid & (tags[rd_index] == rd_tag);
    assign rd_data = data[rd_index][rd_offset];

    // Valid bits: flush clears everything, a completed fill validates the line,
    // and a line is invalidated as soon as it is chosen as a fill victim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
        end else if (flush) begin
            valid_bits <= '0;
        end else if (set_valid) begin
            valid_bits[wr_index] <= 1'b1;
        end else if (clr_valid) begin
            valid_bits[wr_index] <= 1'b0;
        end
    end

    // Tag and data storage carry no reset; the valid bit guards their contents.
    always_ff @(posedge clk) begin
        if (set_valid) begin
            tags[wr_index] <= wr_tag;
        end
        if (wr_en) begin
            data[wr_index][wr_offset] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Instruction cache between the fetch port and the memory arbiter.
// 1- or 2-way set associative with per-set LRU, multi-word block fills,
// and a whole-array flush. Hits are answered combinationally.
module icache_assoc
    import cpu_types_pkg::*;
#(
    parameter int NSETS    = 16,
    parameter int BLKWORDS = 2,
    parameter int ASSOC    = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int OFFB = $clog2(BLKWORDS);
    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = 30 - OFFB - IDXW;
    localparam int CNTW = (OFFB > 0) ? OFFB : 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BLKWORDS - 1);
    localparam word_t BLK_MASK = ~word_t'(BLKWORDS * 4 - 1);

    icache_state_t    state;
    logic [CNTW-1:0]  cnt;
    word_t            fill_addr;
    logic             victim;
    logic [NSETS-1:0] lru;

    logic [IDXW-1:0]  req_index;
    logic [TAGW-1:0]  req_tag;
    logic [CNTW-1:0]  req_offset;
    logic [IDXW-1:0]  fill_index;
    logic [TAGW-1:0]  fill_tag;
    logic [IDXW-1:0]  wr_index;

    logic             way_hit   [2];
    logic             way_valid [2];
    word_t            way_data  [2];

    logic             service;
    logic             any_hit;
    logic             miss_start;
    logic             fill_word;
    logic             fill_last;
    logic             victim_sel;

    assign req_index  = IDXW'(imemaddr >> (2 + OFFB));
    assign req_tag    = TAGW'(imemaddr >> (2 + OFFB + IDXW));
    assign req_offset = CNTW'((imemaddr >> 2) & word_t'(BLKWORDS - 1));
    assign fill_index = IDXW'(fill_addr >> (2 + OFFB));
    assign fill_tag   = TAGW'(fill_addr >> (2 + OFFB + IDXW));
    assign wr_index   = (state == FILL) ? fill_index : req_index;

    assign service    = imemREN & ~(dmemREN | dmemWEN) & ~iflush & (state == IDLE);
    assign any_hit    = way_hit[0] | way_hit[1];
    assign ihit       = service & any_hit;
    assign miss_start = service & ~any_hit;
    assign fill_word  = (state == FILL) & ~iwait;
    assign fill_last  = fill_word & (cnt == LAST_CNT);

    assign iREN  = (state == FILL);
    assign iaddr = iREN ? (fill_addr + (word_t'(cnt) << 2)) : '0;

    // Return the word from whichever way matched; zero when not hitting.
    always_comb begin
        imemload = '0;
        if (ihit) begin
            imemload = way_hit[1] ? way_data[1] : way_data[0];
        end
    end

    // Victim choice: an invalid way first (way 0 preferred), otherwise the LRU way.
    always_comb begin
        victim_sel = 1'b0;
        if (ASSOC == 2) begin
            if (!way_valid[0]) begin
                victim_sel = 1'b0;
            end else if (!way_valid[1]) begin
                victim_sel = 1'b1;
            end else begin
                victim_sel = lru[req_index];
            end
        end
    end

    generate
        for (genvar w = 0; w < 2; w++) begin : g_way
            if (w < ASSOC) begin : g_used
                icache_way #(
                    .NSETS    (NSETS),
                    .BLKWORDS (BLKWORDS),
                    .IDXW     (IDXW),
                    .CNTW     (CNTW),
                    .TAGW     (TAGW)
                ) u_way (
                    .clk       (CLK),
                    .rst_n     (nRST),
                    .rd_index  (req_index),
                    .rd_tag    (req_tag),
                    .rd_offset (req_offset),
                    .hit       (way_hit[w]),
                    .valid     (way_valid[w]),
                    .rd_data   (way_data[w]),
                    .wr_en     (fill_word & (victim == 1'(w))),
                    .wr_index  (wr_index),
                    .wr_offset (cnt),
                    .wr_data   (iload),
                    .wr_tag    (fill_tag),
                    .set_valid (fill_last & ~iflush & (victim == 1'(w))),
                    .clr_valid (miss_start & (victim_sel == 1'(w))),
                    .flush     (iflush)
                );
            end else begin : g_unused
                assign way_hit[w]   = 1'b0;
                assign way_valid[w] = 1'b0;
                assign way_data[w]  = '0;
            end
        end
    endgenerate

    // Fill FSM: latch the block base and victim on a miss, stream BLKWORDS
    // words from memory, and abandon the fill if a flush arrives.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            cnt       <= '0;
            fill_addr <= '0;
            victim    <= 1'b0;
        end else if (iflush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        state     <= FILL;
                        cnt       <= '0;
                        fill_addr <= imemaddr & BLK_MASK;
                        victim    <= victim_sel;
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        if (cnt == LAST_CNT) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // LRU bits point at the way not most recently touched by a hit or a fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lru <= '0;
        end else if (iflush) begin
            lru <= '0;
        end else if (ASSOC == 2) begin
            if (ihit) begin
                lru[req_index] <= ~way_hit[1];
            end else if (fill_last) begin
                lru[fill_index] <= ~victim;
            end
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc (NSETS=16, BLKWORDS=2, ASSOC=2).
// Stimulus queues expected fill addresses and hit data; a monitor compares.
module tb_icache_assoc;

    localparam int NSETS    = 16;
    localparam int BLKWORDS = 2;
    localparam int ASSOC    = 2;
    localparam logic [31:0] BASE_MASK = ~32'(BLKWORDS * 4 - 1);

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int pass_cnt = 0;
    int total_cnt = 0;
    int wait_per_word = 0;
    int stall = 0;

    logic [31:0] exp_fill [$];
    logic [31:0] exp_hit  [$];

    icache_assoc #(
        .NSETS    (NSETS),
        .BLKWORDS (BLKWORDS),
        .ASSOC    (ASSOC)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .iflush   (iflush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    // Memory contents: upper half is the inverted low address half.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign iload = mem_data(iaddr);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory busy model: wait_per_word busy cycles before each transfer.
    initial begin
        iwait = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (iREN && stall < wait_per_word) begin
                iwait = 1'b1;
                stall++;
            end else begin
                iwait = 1'b0;
                stall = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: pops expected memory transfers and hit data as the DUT presents them.
    always @(negedge CLK) begin
        if (nRST) begin
            if (iREN && !iwait) begin
                if (exp_fill.size() == 0) begin
                    checkOutput("fill_unexpected", {31'b0, iREN}, 32'd0);
                end else begin
                    checkOutput("fill_addr", iaddr, exp_fill.pop_front());
                end
            end
            if (ihit) begin
                if (exp_hit.size() == 0) begin
                    checkOutput("ihit_unexpected", {31'b0, ihit}, 32'd0);
                end else begin
                    checkOutput("hit_data", imemload, exp_hit.pop_front());
                end
            end
        end
    end

    // Waits (bounded) for ihit with inputs already applied; checks cycle latency.
    task automatic waitHit(input string name, input int exp_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 60) begin
            @(negedge CLK);
            if (ihit) begin
                seen = 1;
            end else begin
                @(posedge CLK);
                #1;
                lat++;
            end
        end
        checkOutput(name, 32'(lat), 32'(exp_lat));
    endtask

    // Issues one fetch; a miss queues the block's memory transfers.
    task automatic applyStimulus(input logic [31:0] addr, input bit miss, input int exp_lat);
        imemREN  = 1'b1;
        imemaddr = addr;
        if (miss) begin
            for (int k = 0; k < BLKWORDS; k++) begin
                exp_fill.push_back((addr & BASE_MASK) + 32'(4 * k));
            end
        end
        exp_hit.push_back(mem_data(addr));
        waitHit(miss ? "miss_latency" : "hit_latency", exp_lat);
        @(posedge CLK);
        #1;
        imemREN = 1'b0;
    endtask

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        dmemREN  = 1'b0;
        dmemWEN  = 1'b0;
        iflush   = 1'b0;

        #12;
        checkOutput("reset_ihit", {31'b0, ihit}, 32'd0);
        checkOutput("reset_imemload", imemload, 32'd0);
        checkOutput("reset_iren", {31'b0, iREN}, 32'd0);
        checkOutput("reset_iaddr", iaddr, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] cold fetch");
        applyStimulus(32'h0000_0040, 1'b1, BLKWORDS + 1);
        applyStimulus(32'h0000_0044, 1'b0, 0);

        $display("[TB] conflict eviction");
        applyStimulus(32'h0000_0840, 1'b1, BLKWORDS + 1);
        applyStimulus(32'h0000_1040, 1'b1, BLKWORDS + 1);
        applyStimulus(32'h0000_0840, 1'b0, 0);
        applyStimulus(32'h0000_0040, 1'b1, BLKWORDS + 1);

        $display("[TB] LRU update after flush");
        iflush = 1'b1;
        @(posedge CLK);
        #1;
        iflush = 1'b0;
        applyStimulus(32'h0000_0040, 1'b1, BLKWORDS + 1);
        applyStimulus(32'h0000_0840, 1'b1, BLKWORDS + 1);
        applyStimulus(32'h0000_0040, 1'b0, 0);
        applyStimulus(32'h0000_1040, 1'b1, BLKWORDS + 1);
        applyStimulus(32'h0000_0040, 1'b0, 0);
        applyStimulus(32'h0000_0840, 1'b1, BLKWORDS + 1);

        $display("[TB] flush on last fill word");
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        for (int r = 0; r < 2; r++) begin
            exp_fill.push_back(32'h0000_0080);
            exp_fill.push_back(32'h0000_0084);
        end
        exp_hit.push_back(mem_data(32'h0000_0080));
        @(negedge CLK);
        checkOutput("flush_first_miss", {31'b0, ihit}, 32'd0);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        iflush = 1'b1;
        @(negedge CLK);
        checkOutput("flush_cycle_ihit", {31'b0, ihit}, 32'd0);
        @(posedge CLK);
        #1;
        iflush = 1'b0;
        checkOutput("flush_idle_iren", {31'b0, iREN}, 32'd0);
        waitHit("flush_refill_latency", BLKWORDS + 1);
        @(posedge CLK);
        #1;
        imemREN = 1'b0;

        $display("[TB] data access blocks fetch");
        dmemREN  = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0080;
        @(negedge CLK);
        checkOutput("dmem_ihit", {31'b0, ihit}, 32'd0);
        checkOutput("dmem_iren", {31'b0, iREN}, 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("dmem_ihit_hold", {31'b0, ihit}, 32'd0);
        checkOutput("dmem_iren_hold", {31'b0, iREN}, 32'd0);
        @(posedge CLK);
        #1;
        dmemREN = 1'b0;
        exp_hit.push_back(mem_data(32'h0000_0080));
        waitHit("dmem_release_latency", 0);
        @(posedge CLK);
        #1;
        imemREN = 1'b0;

        $display("[TB] stalled fill with address change");
        wait_per_word = 3;
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        exp_fill.push_back(32'h0000_0100);
        exp_fill.push_back(32'h0000_0104);
        @(negedge CLK);
        checkOutput("stall_first_miss", {31'b0, ihit}, 32'd0);
        @(posedge CLK);
        #1;
        imemaddr = 32'h0000_2000;
        imemREN  = 1'b0;
        @(negedge CLK);
        checkOutput("stall_iaddr_latched", iaddr, 32'h0000_0100);
        begin
            int n;
            n = 0;
            while (iREN && n < 60) begin
                @(posedge CLK);
                #1;
                n++;
            end
        end
        checkOutput("stall_fill_done", {31'b0, iREN}, 32'd0);
        wait_per_word = 0;
        @(posedge CLK);
        #1;
        applyStimulus(32'h0000_0100, 1'b0, 0);
        applyStimulus(32'h0000_0104, 1'b0, 0);

        $display("[TB] reset during fill");
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0300;
        @(posedge CLK);
        #2;
        checkOutput("prereset_iren", {31'b0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        checkOutput("async_reset_iren", {31'b0, iREN}, 32'd0);
        checkOutput("async_reset_iaddr", iaddr, 32'd0);
        imemREN = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        applyStimulus(32'h0000_0080, 1'b1, BLKWORDS + 1);

        @(posedge CLK);
        #1;
        checkOutput("fill_queue_drained", 32'(exp_fill.size()), 32'd0);
        checkOutput("hit_queue_drained", 32'(exp_hit.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
